button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Conditions raw push-button/switch inputs into clean, glitch-free levels.
//   Each bit is synchronised to Clock, then accepted only after it has been stable for SAMPLE_COUNT cycles.
//   Sits directly upstream of the level-to-pulse stage: Level[i] drives that stage's Level input.
// PARAMETERS
//   WIDTH         1      number of independent input channels
//   SAMPLE_COUNT  50000  consecutive stable cycles required to accept a change (>=1; 1 ms @ 50 MHz)
//   CNT_WIDTH     16     stability counter width; SAMPLE_COUNT-1 must fit in it
//   ACTIVE_LOW_IN 0      1: RawIn is inverted before synchronisation (pressed = 0 on board)
// PORTS
//   Clock   in   1      system clock, all state on rising edge
//   Reset   in   1      reset Reset, asynchronous, active-low; clock Clock
//   RawIn   in   WIDTH  asynchronous raw button inputs
//   Level   out  WIDTH  debounced level, 1 = pressed
//   Busy    out  WIDTH  1 while channel is qualifying a change (wait states)
// BEHAVIOUR
//   - Per-channel logic is fully independent; channels share nothing but Clock/Reset.
//   - Polarity: in = ACTIVE_LOW_IN ? ~RawIn : RawIn, applied before the synchroniser.
//   - Synchroniser: 2 flops per bit (sync1, sync2), reset to 0; s = sync2.
//   - FSM per bit, 2-bit state reg: LOW, RISE_WAIT, HIGH, FALL_WAIT; CNT_WIDTH counter cnt.
//     LOW:       s=1 -> RISE_WAIT, cnt<=0; else stay.
//     RISE_WAIT: s=0 -> LOW, cnt<=0 (glitch rejected);
//                s=1 & cnt==SAMPLE_COUNT-1 -> HIGH, cnt<=0; else cnt<=cnt+1.
//     HIGH:      s=0 -> FALL_WAIT, cnt<=0; else stay.
//     FALL_WAIT: s=1 -> HIGH, cnt<=0;
//                s=0 & cnt==SAMPLE_COUNT-1 -> LOW, cnt<=0; else cnt<=cnt+1.
//     Unused encodings -> LOW.
//   - Level = state in {HIGH, FALL_WAIT}; Busy = state in {RISE_WAIT, FALL_WAIT}.
//     Both are decoded from registered state only, never from RawIn.
//   - Counter never wraps. It is cleared on every state change and only compared to SAMPLE_COUNT-1.
//   - Latency: RawIn stable from before edge E0 -> Level changes after edge E(SAMPLE_COUNT+2).
//     That is SAMPLE_COUNT+3 rising edges, constant for both directions.
//   - SAMPLE_COUNT=1: a wait state lasts exactly one cycle if s holds.
//   - Any opposite-level sample in a wait state aborts it.
//     A qualified change therefore needs SAMPLE_COUNT consecutive agreeing samples.
//   - Reset (any time, incl. mid-wait): state=LOW, cnt=0, sync=0.
//     Level=0 and Busy=0 immediately (async).
//     After release, a held button re-qualifies with full latency.
//   - Output never toggles more than once per SAMPLE_COUNT+1 cycles.
// TESTING (SAMPLE_COUNT=4 unless stated)
//   1 Reset low with RawIn=1 -> Level=0, Busy=0. Release, hold RawIn=1 -> Busy=1 after E2.
//     Level=1 after E6, Busy=0 after E6.
//   2 RawIn high for 3 cycles then low -> Busy pulses, Level stays 0 throughout.
//   3 Level=1, then RawIn toggles every 2 cycles for 12 cycles, then low.
//     -> Level stays 1 through the bounce; Level=0 exactly 7 edges after the final transition.
//   4 Reset asserted mid-RISE_WAIT (cnt=2) -> Level=0 at once.
//     Release with RawIn=1 -> Level=1 after the full 7 edges.
//   5 WIDTH=2: bit0 pressed, bit1 bouncing -> bit0 latency unaffected, bit1 behaves as in test 3.
//     ACTIVE_LOW_IN=1 with RawIn=0 -> Level=1 after 7 edges.
//   6 Chain to level-to-pulse stage, press with 10-cycle bounce on make and break.
//     -> exactly one 1-cycle Pulse per press.

Source files
------------

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchroniser followed by a
// per-bit stability FSM that accepts a change only after SAMPLE_COUNT agreeing samples.
module button_debouncer #(
    parameter int WIDTH         = 1,
    parameter int SAMPLE_COUNT  = 50000,
    parameter int CNT_WIDTH     = 16,
    parameter bit ACTIVE_LOW_IN = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] RawIn,
    output logic [WIDTH-1:0] Level,
    output logic [WIDTH-1:0] Busy
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(SAMPLE_COUNT - 1);

    logic [WIDTH-1:0] in_pol;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    assign in_pol = ACTIVE_LOW_IN ? ~RawIn : RawIn;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_pol;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t               state;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 s;

        assign s = sync2[i];

        // Any disagreeing sample in a wait state aborts back to the stable state
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                state <= LOW;
                cnt   <= '0;
            end else begin
                case (state)
                    LOW: begin
                        if (s) begin
                            state <= RISE_WAIT;
                            cnt   <= '0;
                        end
                    end
                    RISE_WAIT: begin
                        if (!s) begin
                            state <= LOW;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state <= HIGH;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (!s) begin
                            state <= FALL_WAIT;
                            cnt   <= '0;
                        end
                    end
                    FALL_WAIT: begin
                        if (s) begin
                            state <= HIGH;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state <= LOW;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= LOW;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign Level[i] = (state == HIGH) || (state == FALL_WAIT);
        assign Busy[i]  = (state == RISE_WAIT) || (state == FALL_WAIT);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: vector table plus scoreboarded multi-cycle
// sequences on WIDTH=2, ACTIVE_LOW_IN=1 and SAMPLE_COUNT=1 instances.
`timescale 1ns/1ps
module tb_button_debouncer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [1:0] raw   = 2'b00;
    logic [1:0] lvl;
    logic [1:0] bsy;
    logic       raw_al = 1'b1;
    logic       lvl_al;
    logic       bsy_al;
    logic       raw1 = 1'b0;
    logic       lvl1;
    logic       bsy1;

    always #5 Clock = ~Clock;

    button_debouncer #(
        .WIDTH(2), .SAMPLE_COUNT(4), .CNT_WIDTH(16), .ACTIVE_LOW_IN(1'b0)
    ) dut (
        .Clock(Clock), .Reset(Reset), .RawIn(raw), .Level(lvl), .Busy(bsy)
    );

    button_debouncer #(
        .WIDTH(1), .SAMPLE_COUNT(4), .CNT_WIDTH(16), .ACTIVE_LOW_IN(1'b1)
    ) dut_al (
        .Clock(Clock), .Reset(Reset), .RawIn(raw_al), .Level(lvl_al), .Busy(bsy_al)
    );

    button_debouncer #(
        .WIDTH(1), .SAMPLE_COUNT(1), .CNT_WIDTH(4), .ACTIVE_LOW_IN(1'b0)
    ) dut1 (
        .Clock(Clock), .Reset(Reset), .RawIn(raw1), .Level(lvl1), .Busy(bsy1)
    );

    typedef struct {
        logic [1:0] raw;
        logic [1:0] lvl;
        logic [1:0] bsy;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] lvl;
        logic [1:0] lmask;
        logic [1:0] bsy;
        logic [1:0] bmask;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rises    = 0;
    int   falls    = 0;
    logic mon      = 1'b0;
    logic prev0    = 1'b0;

    always @(negedge Clock) begin
        if (mon && lvl[0] && !prev0) rises++;
        if (mon && !lvl[0] && prev0) falls++;
        prev0 = lvl[0];
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [1:0] l, input logic [1:0] lm,
                                input logic [1:0] b, input logic [1:0] bm);
        exp_t e;
        e.name  = n;
        e.lvl   = l;
        e.lmask = lm;
        e.bsy   = b;
        e.bmask = bm;
        return e;
    endfunction

    // Drive at the falling edge, compare just after the next rising edge.
    task automatic cyc(input logic [1:0] r, input exp_t e);
        exp_t x;
        raw = r;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
        x = exp_q.pop_front();
        check({x.name, "_lvl"}, lvl & x.lmask, x.lvl & x.lmask);
        if (x.bmask != 2'b00)
            check({x.name, "_busy"}, bsy & x.bmask, x.bsy & x.bmask);
        @(negedge Clock);
    endtask

    task automatic bounce(input int n);
        int   t = 0;
        logic v = 1'b1;
        while (t < n) begin
            int run = $urandom_range(1, 3);
            repeat (run) begin
                raw[0] = v;
                @(negedge Clock);
                t++;
            end
            v = ~v;
        end
    endtask

    task automatic pulse_reset();
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];

        // press, release, then a 3-cycle glitch that must be rejected
        tbl.push_back('{2'b11, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 2'b00, 2'b11});
        tbl.push_back('{2'b11, 2'b00, 2'b11});
        tbl.push_back('{2'b11, 2'b00, 2'b11});
        tbl.push_back('{2'b11, 2'b00, 2'b11});
        tbl.push_back('{2'b11, 2'b11, 2'b00});
        tbl.push_back('{2'b00, 2'b11, 2'b00});
        tbl.push_back('{2'b00, 2'b11, 2'b00});
        tbl.push_back('{2'b00, 2'b11, 2'b11});
        tbl.push_back('{2'b00, 2'b11, 2'b11});
        tbl.push_back('{2'b00, 2'b11, 2'b11});
        tbl.push_back('{2'b00, 2'b11, 2'b11});
        tbl.push_back('{2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 2'b00, 2'b11});
        tbl.push_back('{2'b00, 2'b00, 2'b11});
        tbl.push_back('{2'b00, 2'b00, 2'b11});
        tbl.push_back('{2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b00, 2'b00, 2'b00});

        raw = 2'b11;
        repeat (3) @(negedge Clock);
        check("rst_lvl", lvl, 2'b00);
        check("rst_busy", bsy, 2'b00);
        check("rst_lvl_al", {1'b0, lvl_al}, 2'b00);
        check("rst_lvl_sc1", {1'b0, lvl1}, 2'b00);
        Reset = 1'b1;

        foreach (tbl[i])
            cyc(tbl[i].raw, mk($sformatf("tbl%0d", i), tbl[i].lvl, 2'b11, tbl[i].bsy, 2'b11));

        // reset in the middle of a rise qualification, cnt==2
        for (int e = 0; e < 5; e++)
            cyc(2'b11, mk($sformatf("t4_pre%0d", e), 2'b00, 2'b11,
                          (e >= 2) ? 2'b11 : 2'b00, 2'b11));
        Reset = 1'b0;
        #1;
        check("t4_async_busy", bsy, 2'b00);
        check("t4_async_lvl", lvl, 2'b00);
        @(negedge Clock);
        Reset = 1'b1;
        for (int e = 0; e < 7; e++)
            cyc(2'b11, mk($sformatf("t4_req%0d", e), (e == 6) ? 2'b11 : 2'b00, 2'b11,
                          2'b00, 2'b00));
        Reset = 1'b0;
        #1;
        check("t4_async_high", lvl, 2'b00);
        @(negedge Clock);
        Reset = 1'b1;

        // bit0 steady fall, bit1 bouncing: channels must stay independent
        for (int e = 0; e < 7; e++)
            cyc(2'b11, mk($sformatf("t5_up%0d", e), (e == 6) ? 2'b11 : 2'b00, 2'b11,
                          2'b00, 2'b00));
        for (int k = 0; k < 19; k++) begin
            logic b1;
            b1 = (k < 12) && ((k % 4) >= 2);
            cyc({b1, 1'b0}, mk($sformatf("t5_bnc%0d", k), {k < 18, k < 6}, 2'b11,
                               2'b00, 2'b00));
        end

        // active-low input and SAMPLE_COUNT=1 instances
        raw = 2'b00;
        pulse_reset();
        raw_al = 1'b0;
        raw1   = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(posedge Clock);
            #1;
            check($sformatf("al_e%0d", e), {1'b0, lvl_al}, {1'b0, e == 6});
            if (e < 5) begin
                check($sformatf("sc1_lvl_e%0d", e), {1'b0, lvl1}, {1'b0, e >= 3});
                check($sformatf("sc1_busy_e%0d", e), {1'b0, bsy1}, {1'b0, e == 2});
            end
        end
        @(negedge Clock);
        raw1 = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge Clock);
            #1;
            check($sformatf("sc1_fall_e%0d", e), {1'b0, lvl1}, {1'b0, e < 3});
        end
        @(negedge Clock);
        raw1 = 1'b1;
        @(negedge Clock);
        raw1 = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(posedge Clock);
            #1;
            check($sformatf("sc1_glitch_e%0d", e), {1'b0, lvl1}, 2'b00);
        end

        // bouncy make and break: one rising and one falling level edge per press
        @(negedge Clock);
        raw = 2'b00;
        repeat (8) @(negedge Clock);
        mon = 1'b1;
        for (int p = 0; p < 2; p++) begin
            rises = 0;
            falls = 0;
            bounce(10);
            raw[0] = 1'b1;
            repeat (12) @(negedge Clock);
            bounce(10);
            raw[0] = 1'b0;
            repeat (12) @(negedge Clock);
            check($sformatf("t6_rises_p%0d", p), 2'(rises), 2'd1);
            check($sformatf("t6_falls_p%0d", p), 2'(falls), 2'd1);
        end
        mon = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
